// File: rtl/debounce_pkg.sv
// Shared state encoding and sizing helper for the debounce/synchronizer block.
`timescale 1ns/100ps
package debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t LOW      = 2'd0;
    localparam state_t CHK_HIGH = 2'd1;
    localparam state_t HIGH     = 2'd2;
    localparam state_t CHK_LOW  = 2'd3;

    // Counter must hold values up to DEBOUNCE_CYCLES-1 without wrapping.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last stage.
`timescale 1ns/100ps
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronize and debounce a raw level; emit registered level plus edge pulses.
//   state    | meaning
//   LOW      | accepted level 0, synchronized input agrees
//   CHK_HIGH | level 0, counting consecutive 1 samples
//   HIGH     | accepted level 1, synchronized input agrees
//   CHK_LOW  | level 1, counting consecutive 0 samples
`timescale 1ns/100ps
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);

    logic          s;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dout_nxt, rise_nxt, fall_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LOW: begin
                if (s) begin
                    state_nxt = DIRECT ? HIGH : CHK_HIGH;
                    cnt_nxt   = DIRECT ? '0 : CNT_ONE;
                end
            end
            CHK_HIGH: begin
                if (!s) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_nxt = DIRECT ? LOW : CHK_LOW;
                    cnt_nxt   = DIRECT ? '0 : CNT_ONE;
                end
            end
            CHK_LOW: begin
                if (s) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Level is 1 in HIGH and while a fall is still being qualified.
    always_comb begin
        dout_nxt = (state_nxt == HIGH) || (state_nxt == CHK_LOW);
        rise_nxt = dout_nxt & ~dout;
        fall_nxt = ~dout_nxt & dout;
        busy     = (state == CHK_HIGH) || (state == CHK_LOW);
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance plus a 3-stage / 1-cycle instance.
`timescale 1ns/100ps
module tb_debounce_sync;

    localparam int S0 = 2, D0 = 4, S1 = 3, D1 = 1;
    localparam int HN = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;
    logic dout0, rise0, fall0, busy0;
    logic dout1, rise1, fall1, busy1;

    int tests = 0;
    int fails = 0;

    debounce_sync dut0 (
        .clk (clk), .rst_n (rst_n), .din (din),
        .dout (dout0), .rise (rise0), .fall (fall0), .busy (busy0)
    );

    debounce_sync #(.SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1)) dut1 (
        .clk (clk), .rst_n (rst_n), .din (din),
        .dout (dout1), .rise (rise1), .fall (fall1), .busy (busy1)
    );

    always #2 clk = ~clk;

    task automatic check(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: the level flips once the last D samples seen after the
    // synchronizer all differ from it; samples before reset are forgotten.
    bit  dh [2][HN];
    bit  vh [2][HN];
    int  nk [2];
    bit  mdout [2], mrise [2], mfall [2], mbusy [2];

    function automatic void m_reset(input int i);
        nk[i] = 0; mdout[i] = 0; mrise[i] = 0; mfall[i] = 0; mbusy[i] = 0;
    endfunction

    function automatic void m_step(input int i, input bit d, input int S, input int D);
        bit v, all_diff;
        int k;
        if (nk[i] < HN - 1) nk[i]++;
        k = nk[i];
        dh[i][k] = d;
        v = (k > S) ? dh[i][k-S] : 1'b0;
        vh[i][k] = v;
        all_diff = (k >= D);
        for (int j = k - D + 1; j <= k; j++)
            if (j >= 1 && vh[i][j] == mdout[i]) all_diff = 0;
        mrise[i] = 0;
        mfall[i] = 0;
        if (all_diff) begin
            mdout[i] = !mdout[i];
            mrise[i] = mdout[i];
            mfall[i] = !mdout[i];
        end
        mbusy[i] = (v != mdout[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0, din, S0, D0);
            m_step(1, din, S1, D1);
        end
    end

    always @(negedge clk) begin
        check("m_dout0", dout0, mdout[0]);
        check("m_rise0", rise0, mrise[0]);
        check("m_fall0", fall0, mfall[0]);
        check("m_busy0", busy0, mbusy[0]);
        check("m_dout1", dout1, mdout[1]);
        check("m_rise1", rise1, mrise[1]);
        check("m_fall1", fall1, mfall[1]);
        check("m_busy1", busy1, mbusy[1]);
        check("pulse_excl0", rise0 & fall0, 1'b0);
        check("cnt_bound0", int'(dut0.cnt) <= D0 - 1, 1'b1);
        check("cnt_bound1", int'(dut1.cnt) <= D1 - 1, 1'b1);
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit bp [7];
        bit seen_busy;
        bp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // reset with din held high
        din = 1'b1;
        rst_n = 1'b0;
        #5;
        check("rst_dout", dout0, 1'b0);
        check("rst_rise", rise0, 1'b0);
        check("rst_fall", fall0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_dout1", dout1, 1'b0);
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            edge1();
            check("rel_dout", dout0, e >= 6);
            check("rel_rise", rise0, e == 6);
            check("rel_dout1", dout1, e >= 4);
        end

        // clean step up then down
        din = 1'b0;
        repeat (12) edge1();
        din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            edge1();
            check("up_busy", busy0, (e >= 3) && (e <= 5));
            check("up_dout", dout0, e >= 6);
            check("up_rise", rise0, e == 6);
            check("up_dout1", dout1, e >= 4);
            check("up_busy1", busy1, 1'b0);
        end
        repeat (2) edge1();
        din = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            edge1();
            check("dn_busy", busy0, (e >= 3) && (e <= 5));
            check("dn_dout", dout0, e < 6);
            check("dn_fall", fall0, e == 6);
            check("dn_rise", rise0, 1'b0);
        end

        // bounce never qualifies
        repeat (4) edge1();
        seen_busy = 0;
        for (int e = 0; e < 16; e++) begin
            din = (e < 7) ? bp[e] : 1'b0;
            edge1();
            seen_busy |= busy0;
            check("bnc_dout", dout0, 1'b0);
            check("bnc_rise", rise0, 1'b0);
        end
        check("bnc_busy_seen", seen_busy, 1'b1);

        // reset during qualification
        repeat (4) edge1();
        din = 1'b1;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #0.5 rst_n = 1'b0;
        #0.1;
        check("mid_dout", dout0, 1'b0);
        check("mid_busy", busy0, 1'b0);
        check("mid_rise", rise0, 1'b0);
        #2.9 rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            edge1();
            check("mid_rel_rise", rise0, e == 6);
            check("mid_rel_dout", dout0, e >= 6);
        end

        // random flips away from clock edges
        #0.5;
        repeat (53) begin
            din = 1'($urandom_range(0, 1));
            #3;
        end
        din = 1'b0;
        repeat (20) edge1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
